// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped peripheral window:
// register word offsets, TCON bit positions and the default window base.
package mmio_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;

  typedef enum logic [2:0] {
    OFF_TH      = 3'd0,
    OFF_TL      = 3'd1,
    OFF_TCON    = 3'd2,
    OFF_LED     = 3'd3,
    OFF_DIGI    = 3'd4,
    OFF_SYSTICK = 3'd5,
    OFF_RSVD6   = 3'd6,
    OFF_RSVD7   = 3'd7
  } reg_off_e;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;
  localparam int TCON_W  = 3;

  function automatic logic [31:0] tcon_word(input logic [TCON_W-1:0] tcon);
    return {{(32-TCON_W){1'b0}}, tcon};
  endfunction

endpackage

// File: rtl/timer_unit.sv
// Programmable reload timer: TH holds the reload value, TL counts up,
// TCON carries enable / interrupt enable / sticky overflow status.
module timer_unit
  import mmio_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              th_we,
  input  logic              tl_we,
  input  logic              tcon_we,
  input  logic [31:0]       wdata,
  output logic [31:0]       th,
  output logic [31:0]       tl,
  output logic [TCON_W-1:0] tcon,
  output logic              irq
);

  logic overflow;
  logic overflow_set;

  assign overflow     = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
  assign overflow_set = overflow && tcon[TCON_IE];

  // A CPU write to TL beats the count; an overflow set of status beats a CPU clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (th_we) begin
        th <= wdata;
      end

      if (tl_we) begin
        tl <= wdata;
      end else if (overflow) begin
        tl <= th;
      end else if (tcon[TCON_EN]) begin
        tl <= tl + 32'd1;
      end

      if (tcon_we) begin
        tcon[TCON_EN] <= wdata[TCON_EN];
        tcon[TCON_IE] <= wdata[TCON_IE];
        tcon[TCON_ST] <= wdata[TCON_ST] | overflow_set;
      end else if (overflow_set) begin
        tcon[TCON_ST] <= 1'b1;
      end
    end
  end

  assign irq = tcon[TCON_ST] & tcon[TCON_IE];

endmodule

// File: rtl/mmio_peripheral_bus.sv
// Responder for the CPU data-memory bus: decodes a 32-byte register window
// holding the timer, LED and digit registers and a free-running tick counter.
module mmio_peripheral_bus
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          LED_W     = 8,
  parameter int          DIGI_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Address,
  input  logic [31:0]       Write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [31:0]       Read_data,
  output logic              hit,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irq
);

  logic [31:0]       th;
  logic [31:0]       tl;
  logic [TCON_W-1:0] tcon;
  logic [31:0]       systick;
  logic [31:0]       rd_word;
  reg_off_e          word;
  logic              wr_en;
  logic [1:0]        unused_byte_lane;

  assign hit              = (Address[31:5] == BASE_ADDR[31:5]);
  assign word             = reg_off_e'(Address[4:2]);
  assign wr_en            = MemWrite && hit;
  assign unused_byte_lane = Address[1:0];

  timer_unit u_timer (
    .clk     (clk),
    .reset   (reset),
    .th_we   (wr_en && (word == OFF_TH)),
    .tl_we   (wr_en && (word == OFF_TL)),
    .tcon_we (wr_en && (word == OFF_TCON)),
    .wdata   (Write_data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irq)
  );

  // SYSTICK is read-only to software; it just counts clock cycles since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      led     <= '0;
      digi    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (wr_en && (word == OFF_LED)) begin
        led <= Write_data[LED_W-1:0];
      end
      if (wr_en && (word == OFF_DIGI)) begin
        digi <= Write_data[DIGI_W-1:0];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (word)
      OFF_TH:      rd_word = th;
      OFF_TL:      rd_word = tl;
      OFF_TCON:    rd_word = tcon_word(tcon);
      OFF_LED:     rd_word[LED_W-1:0] = led;
      OFF_DIGI:    rd_word[DIGI_W-1:0] = digi;
      OFF_SYSTICK: rd_word = systick;
      default:     rd_word = '0;
    endcase
  end

  assign Read_data = (MemRead && hit) ? rd_word : 32'd0;

endmodule
